// File: rtl/audio_pkg.sv
// Shared definitions for the PONG audio subsystem (capture and playback sides).
package audio_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned SHIFT       = 14;
  localparam int unsigned BOINK_DEPTH = 65405;
  localparam int unsigned WIN_DEPTH   = 15435;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArm    = 2'd1,
    StRecord = 2'd2,
    StDone   = 2'd3
  } cap_state_e;

endpackage

// File: rtl/audio_mono_sat.sv
// L/R average to a saturated 16-bit playback word, plus its magnitude.
module audio_mono_sat
  import audio_pkg::*;
(
  input  logic [31:0]         left_i,
  input  logic [31:0]         right_i,
  output logic [SAMPLE_W-1:0] word_o,
  output logic [SAMPLE_W-1:0] abs_o
);

  localparam int unsigned TopLsb = SHIFT + SAMPLE_W - 1;

  logic [32:0] sum;
  logic [32:0] avg;
  logic        in_range;
  logic        unused_avg;

  assign sum = {left_i[31], left_i} + {right_i[31], right_i};
  assign avg = {sum[32], sum[32:1]};

  // Bits below SHIFT are dropped by the playback format.
  assign unused_avg = ^avg[SHIFT-1:0];

  assign in_range = (avg[32:TopLsb] == '0) || (avg[32:TopLsb] == '1);

  always_comb begin
    if (in_range) begin
      word_o = avg[TopLsb:SHIFT];
    end else if (avg[32]) begin
      word_o = 16'h8000;
    end else begin
      word_o = 16'h7FFF;
    end
  end

  // -16'h8000 wraps back to 16'h8000, which reads correctly as an unsigned magnitude.
  assign abs_o = word_o[SAMPLE_W-1] ? (~word_o + 16'd1) : word_o;

endmodule

// File: rtl/audio_capture.sv
// Record path: drains the mic FIFO, mixes to mono and writes words sequentially into capture RAM.
module audio_capture
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH  = BOINK_DEPTH,
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DECIM  = 1,
  parameter int unsigned THRESH = 0
) (
  input  logic                CLOCK_50,
  input  logic                KEY,
  input  logic                start,
  input  logic                abort,
  input  logic                audio_in_available,
  input  logic [31:0]         left_channel_audio_in,
  input  logic [31:0]         right_channel_audio_in,
  output logic                read_audio_in,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [SAMPLE_W-1:0] mem_data,
  output logic                mem_wren,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sample_count,
  output logic [SAMPLE_W-1:0] peak
);

  localparam int unsigned       DecimW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DecimW-1:0] DecimLast = DecimW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
  localparam logic [SAMPLE_W-1:0] ThreshW = SAMPLE_W'(THRESH);

  cap_state_e          state_q, state_d;
  logic [DecimW-1:0]   decim_q, decim_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;

  logic [SAMPLE_W-1:0] word;
  logic [SAMPLE_W-1:0] word_abs;
  logic                pop;
  logic                keep;
  logic                write;
  logic [ADDR_W-1:0]   waddr;
  logic [DecimW-1:0]   decim_next;

  audio_mono_sat u_mono_sat (
    .left_i  (left_channel_audio_in),
    .right_i (right_channel_audio_in),
    .word_o  (word),
    .abs_o   (word_abs)
  );

  // The FIFO is always drained so the controller never stalls.
  assign pop           = audio_in_available;
  assign read_audio_in = audio_in_available;
  assign keep          = pop && (decim_q == '0);
  assign decim_next    = (decim_q == DecimLast) ? '0 : decim_q + DecimW'(1);

  always_comb begin
    state_d = state_q;
    decim_d = decim_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    count_d = count_q;
    peak_d  = peak_q;
    write   = 1'b0;
    waddr   = addr_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StArm;
            decim_d = '0;
            addr_d  = '0;
            count_d = '0;
            peak_d  = '0;
          end
        end
        StArm: begin
          if (pop) decim_d = decim_next;
          if (keep && (word_abs >= ThreshW)) begin
            write   = 1'b1;
            waddr   = '0;
            state_d = (LastAddr == '0) ? StDone : StRecord;
          end
        end
        StRecord: begin
          if (pop) decim_d = decim_next;
          if (keep) begin
            write = 1'b1;
            waddr = addr_q + ADDR_W'(1);
            if (waddr == LastAddr) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (write) begin
      wren_d  = 1'b1;
      addr_d  = waddr;
      data_d  = word;
      count_d = waddr + ADDR_W'(1);
      peak_d  = (word_abs > peak_q) ? word_abs : peak_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q <= StIdle;
      decim_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      decim_q <= decim_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  assign mem_address  = addr_q;
  assign mem_data     = data_q;
  assign mem_wren     = wren_q;
  assign sample_count = count_q;
  assign peak         = peak_q;
  assign busy         = (state_q == StArm) || (state_q == StRecord);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture: three instances cover plain, triggered and decimated capture.
module tb_audio_capture;

  logic        CLOCK_50;
  logic        KEY;
  logic        start;
  logic        abort;
  logic        avail;
  logic [31:0] left;
  logic [31:0] right;

  logic        a_read, a_wren, a_busy, a_done;
  logic [22:0] a_addr, a_count;
  logic [15:0] a_data, a_peak;
  logic        b_read, b_wren, b_busy, b_done;
  logic [22:0] b_addr, b_count;
  logic [15:0] b_data, b_peak;
  logic        c_read, c_wren, c_busy, c_done;
  logic [22:0] c_addr, c_count;
  logic [15:0] c_data, c_peak;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] word;
    logic [31:0] pk;
  } vec_t;

  vec_t vecs[10];

  audio_capture #(.DEPTH(4), .ADDR_W(23), .DECIM(1), .THRESH(0)) u_dut_a (
    .CLOCK_50 (CLOCK_50), .KEY (KEY), .start (start), .abort (abort),
    .audio_in_available (avail), .left_channel_audio_in (left),
    .right_channel_audio_in (right), .read_audio_in (a_read),
    .mem_address (a_addr), .mem_data (a_data), .mem_wren (a_wren),
    .busy (a_busy), .done (a_done), .sample_count (a_count), .peak (a_peak)
  );

  audio_capture #(.DEPTH(4), .ADDR_W(23), .DECIM(1), .THRESH(100)) u_dut_b (
    .CLOCK_50 (CLOCK_50), .KEY (KEY), .start (start), .abort (abort),
    .audio_in_available (avail), .left_channel_audio_in (left),
    .right_channel_audio_in (right), .read_audio_in (b_read),
    .mem_address (b_addr), .mem_data (b_data), .mem_wren (b_wren),
    .busy (b_busy), .done (b_done), .sample_count (b_count), .peak (b_peak)
  );

  audio_capture #(.DEPTH(4), .ADDR_W(23), .DECIM(3), .THRESH(0)) u_dut_c (
    .CLOCK_50 (CLOCK_50), .KEY (KEY), .start (start), .abort (abort),
    .audio_in_available (avail), .left_channel_audio_in (left),
    .right_channel_audio_in (right), .read_audio_in (c_read),
    .mem_address (c_addr), .mem_data (c_data), .mem_wren (c_wren),
    .busy (c_busy), .done (c_done), .sample_count (c_count), .peak (c_peak)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop(input logic [31:0] l, input logic [31:0] r);
    avail = 1'b1;
    left  = l;
    right = r;
    tick();
    avail = 1'b0;
  endtask

  // L=R=w<<14 makes the mono word exactly w.
  function automatic logic [31:0] wsamp(input int w);
    return 32'(w) << 14;
  endfunction

  task automatic check_zero(input string name, input logic [22:0] cnt, input logic [22:0] addr,
                            input logic [15:0] data, input logic [15:0] pk);
    check(name, 32'(cnt) | 32'(addr) | 32'(data) | 32'(pk), 32'h0);
  endtask

  initial begin
    vecs[0] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF, 32'h7FFF};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h8000, 32'h8000};
    vecs[2] = '{32'h0000_4000, 32'hFFFF_C000, 32'h0000, 32'h0000};
    vecs[3] = '{32'h0001_4000, 32'h0001_4000, 32'h0005, 32'h0005};
    vecs[4] = '{32'hFFFE_C000, 32'hFFFE_C000, 32'hFFFB, 32'h0005};
    vecs[5] = '{32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h7FFF, 32'h7FFF};
    vecs[6] = '{32'h2000_0000, 32'h2000_0000, 32'h7FFF, 32'h7FFF};
    vecs[7] = '{32'hE000_0000, 32'hE000_0000, 32'h8000, 32'h8000};
    vecs[8] = '{32'hDFFF_FFFF, 32'hDFFF_FFFF, 32'h8000, 32'h8000};
    vecs[9] = '{32'h0000_8000, 32'h0000_0000, 32'h0001, 32'h0001};

    KEY = 1'b0; start = 1'b0; abort = 1'b0;
    avail = 1'b1; left = 32'h0001_4000; right = 32'h0001_4000;

    // Reset and idle drain.
    #12;
    check("rst_flags_a", 32'({a_read, a_wren, a_busy, a_done}), 32'b1000);
    check_zero("rst_vals_a", a_count, a_addr, a_data, a_peak);
    @(negedge CLOCK_50);
    KEY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drain_flags_a", 32'({a_read, a_wren, a_busy, a_done}), 32'b1000);
      check("drain_flags_b", 32'({b_read, b_wren, b_busy, b_done}), 32'b1000);
      check("drain_flags_c", 32'({c_read, c_wren, c_busy, c_done}), 32'b1000);
    end
    check_zero("drain_vals_a", a_count, a_addr, a_data, a_peak);
    check_zero("drain_vals_b", b_count, b_addr, b_data, b_peak);
    check_zero("drain_vals_c", c_count, c_addr, c_data, c_peak);
    avail = 1'b0;
    tick();

    // Basic record: four writes of 5, fifth sample discarded.
    pulse_start();
    check("basic_busy", 32'(a_busy), 1);
    avail = 1'b1; left = 32'h0001_4000; right = 32'h0001_4000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("basic_wren", 32'(a_wren), (i < 4) ? 1 : 0);
      if (i < 4) begin
        check("basic_addr", 32'(a_addr), 32'(i));
        check("basic_data", 32'(a_data), 32'h5);
        check("basic_count", 32'(a_count), 32'(i + 1));
      end
      check("basic_done", 32'(a_done), (i >= 3) ? 1 : 0);
    end
    avail = 1'b0;
    check("basic_final_count", 32'(a_count), 4);
    check("basic_final_addr", 32'(a_addr), 3);
    check("basic_final_busy", 32'(a_busy), 0);

    // DONE -> start re-arms with counters cleared.
    pulse_start();
    check("rearm_flags", 32'({a_busy, a_done}), 32'b10);
    check("rearm_count", 32'(a_count), 0);
    check("rearm_peak", 32'(a_peak), 0);

    // Mix/saturation vectors, one single-word recording each.
    for (int i = 0; i < 10; i++) begin
      pulse_abort();
      pulse_start();
      pop(vecs[i].l, vecs[i].r);
      check("mix_wren", 32'(a_wren), 1);
      check("mix_addr", 32'(a_addr), 0);
      check("mix_word", 32'(a_data), vecs[i].word);
      check("mix_peak", 32'(a_peak), vecs[i].pk);
    end

    // Peak accumulates across a recording.
    pulse_abort();
    pulse_start();
    pop(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("peak_1", 32'(a_peak), 32'h7FFF);
    pop(32'h8000_0000, 32'h8000_0000);
    check("peak_2", 32'(a_peak), 32'h8000);
    pop(32'h0000_4000, 32'hFFFF_C000);
    check("peak_3_data", 32'(a_data), 32'h0);
    check("peak_3", 32'(a_peak), 32'h8000);
    check("peak_3_count", 32'(a_count), 3);

    // Trigger at THRESH=100.
    pulse_abort();
    pulse_start();
    begin
      int w[4] = '{10, 99, 100, 5};
      for (int i = 0; i < 4; i++) begin
        pop(wsamp(w[i]), wsamp(w[i]));
        check("trig_busy", 32'(b_busy), 1);
        check("trig_wren", 32'(b_wren), (i >= 2) ? 1 : 0);
        if (i >= 2) begin
          check("trig_addr", 32'(b_addr), 32'(i - 2));
          check("trig_data", 32'(b_data), 32'(w[i]));
        end
      end
    end
    check("trig_count", 32'(b_count), 2);
    check("trig_peak", 32'(b_peak), 100);

    // Decimation by 3.
    pulse_abort();
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      pop(wsamp(k), wsamp(k));
      check("decim_wren", 32'(c_wren), (k % 3 == 1) ? 1 : 0);
      if (k % 3 == 1) begin
        check("decim_addr", 32'(c_addr), 32'((k - 1) / 3));
        check("decim_data", 32'(c_data), 32'(k));
      end
    end
    check("decim_count", 32'(c_count), 3);
    check("decim_done", 32'(c_done), 0);

    // Abort on a pop mid-record suppresses the write.
    pulse_abort();
    pulse_start();
    pop(wsamp(1), wsamp(1));
    pop(wsamp(2), wsamp(2));
    check("abort_pre_count", 32'(a_count), 2);
    avail = 1'b1; left = wsamp(3); right = wsamp(3); abort = 1'b1;
    tick();
    avail = 1'b0; abort = 1'b0;
    check("abort_wren", 32'(a_wren), 0);
    check("abort_flags", 32'({a_busy, a_done}), 0);
    check("abort_count", 32'(a_count), 2);
    check("abort_addr", 32'(a_addr), 1);
    check("abort_peak", 32'(a_peak), 2);

    // start with abort stays idle; start alone arms.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(a_busy), 0);
    check("start_abort_count", 32'(a_count), 2);
    pulse_start();
    check("restart_busy", 32'(a_busy), 1);
    check("restart_count", 32'(a_count), 0);

    // Asynchronous reset mid-record.
    pop(wsamp(7), wsamp(7));
    pop(wsamp(8), wsamp(8));
    check("pre_reset_wren", 32'(a_wren), 1);
    #2 KEY = 1'b0;
    #1;
    check("async_flags", 32'({a_wren, a_busy, a_done}), 0);
    check_zero("async_vals", a_count, a_addr, a_data, a_peak);
    @(negedge CLOCK_50);
    KEY = 1'b1;
    tick();
    check("post_reset_busy", 32'(a_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_capture.md
Name: audio_capture

Overview:
- Record path of the PONG audio subsystem: drains mic samples from Audio_Controller's input FIFO, mixes L/R to mono, saturates to 16 bits and writes them sequentially into a capture RAM.
- The capture RAM uses the same word format and addressing as the boink/win playback ROMs, so a captured clip replays through the existing playback path unchanged.
- Optional amplitude trigger: recording starts on the first loud sample after arming.

Parameters:
- DEPTH, 65405, number of 16-bit words captured per recording (last address DEPTH-1).
- ADDR_W, 23, width of the RAM address and sample counter.
- DECIM, 1, keep 1 of every DECIM popped samples (1 = keep all).
- THRESH, 0, trigger level compared against |mono word|; 0 = start immediately.

Ports:
- CLOCK_50  in  1  50 MHz system clock; all state on rising edge.
- KEY  in  1  asynchronous active-low reset (0 = reset).
- start  in  1  one-cycle pulse: arm a new recording.
- abort  in  1  one-cycle pulse: stop immediately, return to IDLE.
- audio_in_available  in  1  Audio_Controller input FIFO non-empty.
- left_channel_audio_in  in  32  signed left sample.
- right_channel_audio_in  in  32  signed right sample.
- read_audio_in  out  1  pop strobe to Audio_Controller.
- mem_address  out  ADDR_W  capture RAM write address.
- mem_data  out  16  capture RAM write data.
- mem_wren  out  1  capture RAM write enable, one cycle per word.
- busy  out  1  high in ARM or RECORD.
- done  out  1  high in DONE.
- sample_count  out  ADDR_W  words written in the current or last recording.
- peak  out  16  largest |word| written since the last start.

Behaviour:
- Reset (KEY=0, asynchronous): state IDLE; read_audio_in=0 is not registered (see below); mem_address=0, mem_data=0, mem_wren=0, busy=0, done=0, sample_count=0, peak=0, decimation counter=0.
- read_audio_in = audio_in_available, combinational, in every state. The FIFO is always drained so the controller never stalls; samples popped in IDLE or DONE are discarded. A sample is "popped" on any cycle where audio_in_available=1.
- Mono word:
  - sum = sign-extended 33-bit L + R; avg = sum >>> 1.
  - word = avg[29:14], so the playback shift (word << 14) reconstructs the input.
  - If avg[32:29] is not all-equal, saturate: positive to 16'h7FFF, negative to 16'h8000.
- Decimation: counter increments on each pop in ARM/RECORD and wraps at DECIM-1. A pop is eligible only when the counter is 0. The counter clears on start.
- States:
  - IDLE: start -> ARM; clears sample_count, peak, decim counter, mem_address=0.
  - ARM: on an eligible pop with |word| >= THRESH (abs of 16'h8000 = 16'h8000, unsigned compare), write the word at address 0 and go to RECORD. Non-qualifying samples are discarded.
  - RECORD: each eligible pop writes the word at the next address.
  - DONE: entered after the write at address DEPTH-1. Holds until start (-> ARM, counters cleared) or abort (-> IDLE).
- Write timing:
  - mem_address, mem_data and mem_wren are registered: 1-cycle latency from the pop.
  - mem_wren is high for exactly one cycle per word.
  - mem_address holds the address of the last write; it increments before each subsequent write and never exceeds DEPTH-1 (no wrap).
  - sample_count and peak update in the same cycle as mem_wren.
- Priority: abort > start.
  - abort in any state -> IDLE next cycle and suppresses any pending write from that cycle's pop.
  - sample_count and peak are retained after abort.
  - start in ARM or RECORD is ignored.
  - start and abort in the same cycle -> IDLE.
- busy = (ARM or RECORD); done = DONE, registered with the state.

Decomposition:
- Shared package audio_pkg: state encoding (IDLE, ARM, RECORD, DONE), SAMPLE_W=16, SHIFT=14 (shared with the playback side), ROM depth constants 65405/15435.
- One sub-module, audio_mono_sat: combinational L/R average plus saturation to a 16-bit word, and an abs output for the trigger/peak compare. It is reused by a future level meter.

Test Plan:
- Reset/idle drain: KEY=0 then 1, audio_in_available held 1, no start -> read_audio_in=1 every cycle, mem_wren never 1, all outputs 0.
- Basic record, DEPTH=4, DECIM=1, THRESH=0: start, then 5 pops with L=R=32'h0001_4000 -> four writes of 16'h0005 at addresses 0..3, each 1 cycle after its pop; done=1; 5th sample discarded; sample_count=4.
- Saturation/mix: L=32'h7FFF_FFFF, R=32'h7FFF_FFFF -> 16'h7FFF. L=R=32'h8000_0000 -> 16'h8000. L=32'h0000_4000, R=32'hFFFF_C000 -> 16'h0000. peak is 16'h8000 after the negative case.
- Trigger, THRESH=100: samples with words 10, 99, 100, 5 -> first write is 100 at address 0, then 5 at address 1; busy=1 throughout ARM and RECORD.
- Decimation, DECIM=3: 9 pops with words 1..9 -> writes 1, 4, 7 at addresses 0, 1, 2.
- Abort/restart: abort in the same cycle as a pop mid-RECORD -> no write for that pop, IDLE next cycle, sample_count retained. Then start and abort together -> stays IDLE. Then start alone -> ARM with sample_count=0. Async KEY=0 mid-RECORD clears everything immediately.
